// File: rtl/mc_control.sv
`default_nettype none
// ============================================================================
// Module      : mc_control
// Description : Multi-cycle processor controller with a bus-ack watchdog and
//               trap handling. Define MC_CONTROL_MDU_EN for multiply/divide sequencing.
// Revision    : 1.0 - initial release
// ============================================================================
module mc_control #(
    parameter int ACK_TIMEOUT = 255,
    parameter int MDU_CYCLES  = 32
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [5:0] i_con_instru,
    input  logic [5:0] i_con_funct,
    input  logic       i_con_memack,
    input  logic       i_con_trapclr,
    output logic       o_con_regdst,
    output logic       o_con_alusrc,
    output logic       o_con_ifsign,
    output logic [5:0] o_con_aluop,
    output logic [1:0] o_con_loadsig,
    output logic       o_con_memread,
    output logic       o_con_memwrite,
    output logic       o_con_memtoreg,
    output logic       o_con_regwrite,
    output logic       o_con_memreq,
    output logic       o_con_irwrite,
    output logic       o_con_pcwrite,
    output logic       o_con_pcwritecond,
    output logic       o_con_bne,
    output logic [2:0] o_con_state,
    output logic       o_con_busy,
    output logic       o_con_trap,
    output logic [1:0] o_con_cause
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_MDU    = 3'd6,
        S_TRAP   = 3'd7
    } state_t;

    localparam logic [15:0] c_ack_last = 16'(ACK_TIMEOUT - 1);

    state_t      r_state;
    logic [5:0]  r_opcode;
    logic [15:0] r_wait;
    logic [1:0]  r_cause;

    logic w_in_legal;
    logic w_legal;
    logic w_rtype, w_alui, w_load, w_store, w_jump, w_beq, w_bne;
    logic w_dec_en;

`ifdef MC_CONTROL_MDU_EN
    localparam logic [7:0] c_mdu_last = 8'(MDU_CYCLES - 1);
    logic [5:0] r_funct;
    logic [7:0] r_mdu;
    logic       w_mdu_op;
    assign w_mdu_op = w_rtype && (r_funct inside {6'b011000, 6'b011001, 6'b011010, 6'b011011});
`endif

    // Legality is judged on the live opcode while in DECODE.
    assign w_in_legal = (i_con_instru inside {6'b000000, 6'b001000, 6'b001001, 6'b001100,
                                              6'b001101, 6'b001110, 6'b001010, 6'b001111,
                                              6'b100011, 6'b100100, 6'b100101, 6'b000010,
                                              6'b000100, 6'b000101})
                     || (i_con_instru[5:3] == 3'b101);
`ifdef MC_CONTROL_MDU_EN
    assign w_legal = w_in_legal;
`else
    assign w_legal = w_in_legal && !((i_con_instru == 6'b000000) &&
                     (i_con_funct inside {6'b011000, 6'b011001, 6'b011010, 6'b011011}));
`endif

    assign w_rtype = (r_opcode == 6'b000000);
    assign w_alui  = (r_opcode[5:3] == 3'b001);
    assign w_load  = (r_opcode inside {6'b100011, 6'b100100, 6'b100101});
    assign w_store = (r_opcode[5:3] == 3'b101);
    assign w_jump  = (r_opcode == 6'b000010);
    assign w_beq   = (r_opcode == 6'b000100);
    assign w_bne   = (r_opcode == 6'b000101);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state  <= S_IDLE;
            r_opcode <= '0;
            r_wait   <= '0;
            r_cause  <= 2'b00;
`ifdef MC_CONTROL_MDU_EN
            r_funct  <= '0;
            r_mdu    <= '0;
`endif
        end else begin
            // The wait counter only survives while FETCH or MEM keeps waiting.
            r_wait <= '0;
            case (r_state)
                S_IDLE: r_state <= S_FETCH;
                S_FETCH: begin
                    if (i_con_memack) begin
                        r_state <= S_DECODE;
                    end else if (r_wait == c_ack_last) begin
                        r_state <= S_TRAP;
                        r_cause <= 2'b10;
                    end else begin
                        r_wait <= r_wait + 16'd1;
                    end
                end
                S_DECODE: begin
                    r_opcode <= i_con_instru;
`ifdef MC_CONTROL_MDU_EN
                    r_funct  <= i_con_funct;
`endif
                    if (w_legal) begin
                        r_state <= S_EXEC;
                    end else begin
                        r_state <= S_TRAP;
                        r_cause <= 2'b01;
                    end
                end
                S_EXEC: begin
                    if (w_load || w_store) begin
                        r_state <= S_MEM;
                    end else if (w_jump || w_beq || w_bne) begin
                        r_state <= S_FETCH;
`ifdef MC_CONTROL_MDU_EN
                    end else if (w_mdu_op) begin
                        r_state <= S_MDU;
                        r_mdu   <= '0;
`endif
                    end else begin
                        r_state <= S_WB;
                    end
                end
                S_MEM: begin
                    if (i_con_memack) begin
                        r_state <= w_load ? S_WB : S_FETCH;
                    end else if (r_wait == c_ack_last) begin
                        r_state <= S_TRAP;
                        r_cause <= 2'b10;
                    end else begin
                        r_wait <= r_wait + 16'd1;
                    end
                end
                S_WB: r_state <= S_FETCH;
`ifdef MC_CONTROL_MDU_EN
                S_MDU: begin
                    if (r_mdu == c_mdu_last) begin
                        r_state <= S_FETCH;
                    end else begin
                        r_mdu <= r_mdu + 8'd1;
                    end
                end
`endif
                S_TRAP: begin
                    if (i_con_trapclr) begin
                        r_state <= S_FETCH;
                        r_cause <= 2'b00;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign w_dec_en = (r_state == S_EXEC) || (r_state == S_MEM) ||
                      (r_state == S_WB)   || (r_state == S_MDU);

    always_comb begin
        o_con_regdst      = 1'b0;
        o_con_alusrc      = 1'b0;
        o_con_ifsign      = 1'b0;
        o_con_aluop       = 6'b000000;
        o_con_loadsig     = 2'b00;
        o_con_memread     = 1'b0;
        o_con_memwrite    = 1'b0;
        o_con_memtoreg    = 1'b0;
        o_con_regwrite    = 1'b0;
        o_con_memreq      = 1'b0;
        o_con_irwrite     = 1'b0;
        o_con_pcwrite     = 1'b0;
        o_con_pcwritecond = 1'b0;
        o_con_bne         = 1'b0;
        if (w_dec_en) begin
            o_con_regdst = w_rtype;
            o_con_alusrc = w_alui || w_load || w_store;
            o_con_ifsign = (r_opcode == 6'b001000);
            case (r_opcode)
                6'b000000:            o_con_aluop = 6'b000010;
                6'b001000, 6'b001001: o_con_aluop = 6'b000011;
                6'b001100:            o_con_aluop = 6'b000111;
                6'b001101:            o_con_aluop = 6'b001011;
                6'b001110:            o_con_aluop = 6'b001111;
                6'b001010:            o_con_aluop = 6'b011011;
                6'b001111:            o_con_aluop = 6'b011111;
                6'b000010, 6'b000100, 6'b000101: o_con_aluop = 6'b000001;
                default:              o_con_aluop = 6'b000000;
            endcase
            if (r_opcode == 6'b100100)      o_con_loadsig = 2'b10;
            else if (r_opcode == 6'b100101) o_con_loadsig = 2'b01;
        end
        case (r_state)
            S_FETCH: begin
                o_con_memreq  = 1'b1;
                o_con_memread = 1'b1;
                o_con_irwrite = i_con_memack;
                o_con_pcwrite = i_con_memack;
            end
            S_EXEC: begin
                o_con_pcwrite     = w_jump;
                o_con_pcwritecond = w_beq || w_bne;
                o_con_bne         = w_bne;
            end
            S_MEM: begin
                o_con_memreq   = 1'b1;
                o_con_memread  = w_load;
                o_con_memwrite = w_store;
            end
            S_WB: begin
                o_con_regwrite = 1'b1;
                o_con_memtoreg = w_load;
            end
            default: ;
        endcase
    end

    assign o_con_state = r_state;
    assign o_con_busy  = (r_state != S_IDLE) && (r_state != S_TRAP);
    assign o_con_trap  = (r_state == S_TRAP);
    assign o_con_cause = r_cause;

endmodule
`default_nettype wire

// File: tb/tb_mc_control.sv
`default_nettype none
// ============================================================================
// Module      : tb_mc_control
// Description : Directed self-checking bench for mc_control (ACK_TIMEOUT=4, MDU_CYCLES=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mc_control;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] instru;
    logic [5:0] funct;
    logic       memack;
    logic       trapclr;
    logic       regdst, alusrc, ifsign;
    logic [5:0] aluop;
    logic [1:0] loadsig;
    logic       memread, memwrite, memtoreg, regwrite;
    logic       memreq, irwrite, pcwrite, pcwritecond, bne;
    logic [2:0] state;
    logic       busy, trap;
    logic [1:0] cause;
    logic [26:0] all_out;

    int checks = 0;
    int errors = 0;

    mc_control #(
        .ACK_TIMEOUT(4),
        .MDU_CYCLES (4)
    ) dut (
        .i_clk            (clk),
        .i_rst            (rst),
        .i_con_instru     (instru),
        .i_con_funct      (funct),
        .i_con_memack     (memack),
        .i_con_trapclr    (trapclr),
        .o_con_regdst     (regdst),
        .o_con_alusrc     (alusrc),
        .o_con_ifsign     (ifsign),
        .o_con_aluop      (aluop),
        .o_con_loadsig    (loadsig),
        .o_con_memread    (memread),
        .o_con_memwrite   (memwrite),
        .o_con_memtoreg   (memtoreg),
        .o_con_regwrite   (regwrite),
        .o_con_memreq     (memreq),
        .o_con_irwrite    (irwrite),
        .o_con_pcwrite    (pcwrite),
        .o_con_pcwritecond(pcwritecond),
        .o_con_bne        (bne),
        .o_con_state      (state),
        .o_con_busy       (busy),
        .o_con_trap       (trap),
        .o_con_cause      (cause)
    );

    always #5 clk = ~clk;

    assign all_out = {regdst, alusrc, ifsign, aluop, loadsig, memread, memwrite,
                      memtoreg, regwrite, memreq, irwrite, pcwrite, pcwritecond,
                      bne, state, busy, trap, cause};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // From FETCH: ack immediately, pass through DECODE, land in the post-decode state.
    task automatic fetch_decode(input logic [5:0] op, input logic [5:0] fn);
        instru = op;
        funct  = fn;
        memack = 1'b1;
        tick();
        memack = 1'b0;
        tick();
    endtask

    task automatic clear_trap();
        trapclr = 1'b1;
        tick();
        trapclr = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; instru = '0; funct = '0; memack = 1'b0; trapclr = 1'b0;
        tick();
        tick();
        chk("reset_outputs", 32'(all_out), 32'd0);
        rst = 1'b0;
        #1 chk("idle_after_release", 32'(state), 32'd0);

        // addi with ack on the third FETCH cycle
        instru = 6'b001000;
        tick();
        chk("fetch_entry", 32'(state), 32'd1);
        chk("fetch_busy", 32'(busy), 32'd1);
        chk("fetch_wait_strobes", 32'({memreq, memread, irwrite, pcwrite}), 32'b1100);
        tick();
        chk("fetch_cycle2", 32'(state), 32'd1);
        tick();
        memack = 1'b1;
        #1 chk("fetch_ack_strobes", 32'({memreq, memread, irwrite, pcwrite}), 32'b1111);
        chk("fetch_cycle3", 32'(state), 32'd1);
        tick();
        memack = 1'b0;
        chk("addi_decode", 32'(state), 32'd2);
        tick();
        chk("addi_exec", 32'(state), 32'd3);
        tick();
        chk("addi_wb_state", 32'(state), 32'd5);
        chk("addi_wb_ctrl", 32'({regwrite, alusrc, ifsign, regdst, memtoreg, aluop}),
            32'({5'b11100, 6'b000011}));
        tick();
        chk("addi_to_fetch", 32'(state), 32'd1);

        // lbu, immediate acks (ack raised during EXEC must be ignored)
        fetch_decode(6'b100100, 6'd0);
        chk("lbu_exec_state", 32'(state), 32'd3);
        chk("lbu_exec_ctrl", 32'({alusrc, loadsig, aluop}), 32'({1'b1, 2'b10, 6'b0}));
        memack = 1'b1;
        tick();
        chk("lbu_mem_state", 32'(state), 32'd4);
        chk("lbu_mem_strobes", 32'({memreq, memread, memwrite}), 32'b110);
        tick();
        memack = 1'b0;
        chk("lbu_wb_state", 32'(state), 32'd5);
        chk("lbu_wb_ctrl", 32'({regwrite, memtoreg, loadsig}), 32'b1110);
        tick();
        chk("lbu_to_fetch", 32'(state), 32'd1);

        // sw
        fetch_decode(6'b101011, 6'd0);
        chk("sw_exec", 32'({state, regwrite, alusrc, aluop}), 32'({3'd3, 1'b0, 1'b1, 6'b0}));
        memack = 1'b1;
        tick();
        chk("sw_mem", 32'({state, memreq, memread, memwrite, regwrite}), 32'({3'd4, 4'b1010}));
        tick();
        memack = 1'b0;
        chk("sw_to_fetch", 32'({state, regwrite}), 32'({3'd1, 1'b0}));

        // R-type add
        fetch_decode(6'b000000, 6'b100000);
        chk("rtype_exec", 32'({state, regdst, alusrc, aluop}), 32'({3'd3, 2'b10, 6'b000010}));
        tick();
        chk("rtype_wb", 32'({state, regwrite, memtoreg}), 32'({3'd5, 2'b10}));
        tick();

        // bne and j
        fetch_decode(6'b000101, 6'd0);
        chk("bne_exec", 32'({pcwrite, pcwritecond, bne, alusrc, aluop}), 32'({4'b0110, 6'b000001}));
        tick();
        chk("bne_to_fetch", 32'(state), 32'd1);
        fetch_decode(6'b000010, 6'd0);
        chk("j_exec", 32'({state, pcwrite, pcwritecond, bne}), 32'({3'd3, 3'b100}));
        tick();
        chk("j_to_fetch", 32'(state), 32'd1);

        // illegal opcode
        fetch_decode(6'b111111, 6'd0);
        chk("illegal_trap", 32'({state, trap, cause, busy}), 32'({3'd7, 4'b1010}));
        chk("trap_strobes", 32'({memreq, memread, memwrite, regwrite, irwrite, pcwrite, aluop}), 32'd0);
        memack = 1'b1;
        tick();
        memack = 1'b0;
        chk("trap_ignores_ack", 32'({state, cause}), 32'({3'd7, 2'b01}));
        clear_trap();
        chk("trapclr_exit", 32'({state, cause}), 32'({3'd1, 2'b00}));

        // FETCH timeout after 4 wait cycles; trapclr in FETCH is ignored
        trapclr = 1'b1;
        tick();
        trapclr = 1'b0;
        chk("trapclr_ignored", 32'(state), 32'd1);
        tick();
        tick();
        chk("timeout_cycle4", 32'(state), 32'd1);
        tick();
        chk("fetch_timeout", 32'({state, cause}), 32'({3'd7, 2'b10}));
        clear_trap();

        // ack on the 4th FETCH cycle wins over the timeout
        tick();
        tick();
        tick();
        instru = 6'b001101;
        memack = 1'b1;
        tick();
        memack = 1'b0;
        chk("ack_beats_timeout", 32'(state), 32'd2);
        tick();
        chk("ori_exec", 32'({state, aluop}), 32'({3'd3, 6'b001011}));
        tick();
        tick();

        // MEM timeout with lw
        fetch_decode(6'b100011, 6'd0);
        tick();
        tick();
        tick();
        tick();
        chk("mem_cycle4", 32'(state), 32'd4);
        tick();
        chk("mem_timeout", 32'({state, cause}), 32'({3'd7, 2'b10}));
        clear_trap();

        // multiply/divide funct
        fetch_decode(6'b000000, 6'b011000);
`ifdef MC_CONTROL_MDU_EN
        chk("mdu_exec", 32'(state), 32'd3);
        tick();
        chk("mdu_first", 32'({state, regwrite}), 32'({3'd6, 1'b0}));
        tick();
        tick();
        tick();
        chk("mdu_fourth", 32'({state, regwrite}), 32'({3'd6, 1'b0}));
        tick();
        chk("mdu_to_fetch", 32'(state), 32'd1);
`else
        chk("mdu_illegal", 32'({state, cause}), 32'({3'd7, 2'b01}));
        clear_trap();
`endif

        // asynchronous reset mid-handshake
        chk("pre_reset_fetch", 32'(state), 32'd1);
        #2 rst = 1'b1;
        #1 chk("async_reset", 32'(all_out), 32'd0);
        tick();
        rst = 1'b0;
        chk("reset_hold_idle", 32'(state), 32'd0);
        tick();
        chk("reset_to_fetch", 32'(state), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
